gpio_bus_initiator: RTL and testbench

GPIO_BUS_INITIATOR -- requirements
Module: gpio_bus_initiator

---
 rtl/gpio_bus_initiator.sv | 136 +++++++++++++
 tb/tb_gpio_bus_initiator.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_initiator.sv
// gpio_bus_initiator: turns valid/ready commands into strobed register-bus cycles with a read response path
module gpio_bus_initiator #(
    parameter int AddrWidth    = 16,
    parameter int BusWidth     = 32,
    parameter int StrobeCycles = 1,
    parameter int ReadLatency  = 5,
    parameter int WriteSettle  = 4,
    parameter int GapCycles    = 2
) (
    input  logic                 reg_clk,
    input  logic                 reset_in,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [BusWidth-1:0]  cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BusWidth-1:0]  rsp_rdata,
    output logic                 busy,
    output logic                 chip_sel,
    output logic                 write_reg,
    output logic                 read_reg,
    output logic [AddrWidth-3:0] busaddress,
    output logic [BusWidth-1:0]  busdata_in,
    input  logic [BusWidth-1:0]  busdata_to_cpu
);
    typedef enum logic [2:0] {IDLE, STROBE, WAIT, RESP, GAP} state_e;
    localparam logic [3:0] StbLd = 4'(StrobeCycles - 1);
    localparam logic [3:0] RdLd  = 4'(ReadLatency - 1);
    localparam logic [3:0] WrLd  = 4'(WriteSettle - 1);
    localparam logic [3:0] GapLd = 4'(GapCycles - 1);
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [AddrWidth-3:0]  addr_q, addr_d;
    logic [BusWidth-1:0]   wdata_q, wdata_d;
    logic [BusWidth-1:0]   rdata_q, rdata_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  busy_q, busy_d;
    logic                  cs_q, cs_d;
    logic                  wreg_q, wreg_d;
    logic                  rreg_q, rreg_d;
    logic [AddrWidth-3:0]  baddr_q, baddr_d;
    logic [BusWidth-1:0]   bdata_q, bdata_d;
    logic                  on_bus, in_strobe;
    logic                  unused_addr_lsbs;
    assign unused_addr_lsbs = ^cmd_addr[1:0];
    // next-state, counters and the registered output values derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                state_d = STROBE;
                cnt_d   = StbLd;
                wr_d    = cmd_write;
                addr_d  = cmd_addr[AddrWidth-1:2];
                wdata_d = cmd_wdata;
            end
            STROBE: if (cnt_q == 4'd0) begin
                state_d = WAIT;
                cnt_d   = wr_q ? WrLd : RdLd;
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d = wr_q ? GAP : RESP;
                cnt_d   = GapLd;
                rdata_d = wr_q ? rdata_q : busdata_to_cpu;
            end
            RESP: if (rsp_ready) begin
                state_d = GAP;
                cnt_d   = GapLd;
            end
            GAP: state_d = (cnt_q == 4'd0) ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
        on_bus      = (state_d == STROBE) || (state_d == WAIT);
        in_strobe   = state_d == STROBE;
        cmd_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
        busy_d      = state_d != IDLE;
        cs_d        = on_bus;
        wreg_d      = in_strobe && wr_d;
        rreg_d      = in_strobe && !wr_d;
        baddr_d     = on_bus ? addr_d : '0;
        bdata_d     = on_bus ? wdata_d : '0;
    end
    // state, command and output registers; reset clears the bus immediately
    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b0;
            wreg_q      <= 1'b0;
            rreg_q      <= 1'b0;
            baddr_q     <= '0;
            bdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            wreg_q      <= wreg_d;
            rreg_q      <= rreg_d;
            baddr_q     <= baddr_d;
            bdata_q     <= bdata_d;
        end
    end
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign busy       = busy_q;
    assign chip_sel   = cs_q;
    assign write_reg  = wreg_q;
    assign read_reg   = rreg_q;
    assign busaddress = baddr_q;
    assign busdata_in = bdata_q;
endmodule

// File: tb/tb_gpio_bus_initiator.sv
// tb_gpio_bus_initiator: scoreboard bench for the default and a short-timing initiator
module tb_gpio_bus_initiator;
    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] shadow[256];
    logic [31:0] mem[256];
    logic        ovr_en = 1'b0;
    logic [31:0] ovr = '0;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, busy, chip_sel, write_reg, read_reg;
    logic [31:0] rsp_rdata, busdata_in, busdata_to_cpu;
    logic [13:0] busaddress;

    logic        b_valid = 1'b0, b_write = 1'b0, b_rsp_ready = 1'b0;
    logic [15:0] b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_rd = 32'h5A5A0003;
    logic        b_ready, b_rsp_valid, b_busy, b_cs, b_wreg, b_rreg;
    logic [31:0] b_rdata, b_bdata;
    logic [13:0] b_baddr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (write_reg) mem[busaddress[7:0]] <= busdata_in;
    assign busdata_to_cpu = ovr_en ? ovr : mem[busaddress[7:0]];

    gpio_bus_initiator dut (
        .reg_clk(clk), .reset_in(reset_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .chip_sel(chip_sel), .write_reg(write_reg), .read_reg(read_reg),
        .busaddress(busaddress), .busdata_in(busdata_in), .busdata_to_cpu(busdata_to_cpu)
    );

    gpio_bus_initiator #(.StrobeCycles(3), .ReadLatency(1), .GapCycles(1)) dut2 (
        .reg_clk(clk), .reset_in(reset_in),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(b_write),
        .cmd_addr(b_addr), .cmd_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rdata),
        .busy(b_busy), .chip_sel(b_cs), .write_reg(b_wreg), .read_reg(b_rreg),
        .busaddress(b_baddr), .busdata_in(b_bdata), .busdata_to_cpu(b_rd)
    );

    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, output int hs);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout cmd_ready=%b required=1", cmd_ready);
        end
        @(posedge clk);
        #1;
        hs = cyc;
        if (w) shadow[a[9:2]] = d;
    endtask

    task automatic get_rsp(output logic [31:0] data, output int vcyc);
        vcyc = -1;
        data = 'x;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                vcyc = cyc;
                break;
            end
        end
        if (vcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
        end else begin
            data = rsp_rdata;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, busy, chip_sel, write_reg, read_reg} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=000000", {cmd_ready, rsp_valid, busy, chip_sel, write_reg, read_reg});
        end
        checks++;
        if (busaddress !== 14'h0 || busdata_in !== 32'h0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h data=%h rdata=%h required=0", busaddress, busdata_in, rsp_rdata);
        end
        reset_in = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b%b required=11", cmd_ready, b_ready);
        end
    endtask

    task automatic test_write;
        int hs, nwr, ncs, nrd, rdy;
        logic [13:0] a;
        logic [31:0] d;
        logic rspany;
        nwr = 0; ncs = 0; nrd = 0; rdy = 0; rspany = 0; a = '0; d = '0;
        issue(1'b1, 16'h1100, 32'h00FFFFFF, hs);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (write_reg) begin
                nwr++;
                a = busaddress;
                d = busdata_in;
            end
            if (read_reg) nrd++;
            if (chip_sel) ncs++;
            if (rsp_valid) rspany = 1'b1;
            if (cmd_ready && rdy == 0) rdy = i;
        end
        checks++;
        if (nwr != 1) begin errors++; $display("FAIL write_strobe_len got=%0d required=1", nwr); end
        checks++;
        if (ncs != 5) begin errors++; $display("FAIL write_cs_len got=%0d required=5", ncs); end
        checks++;
        if (a !== 14'h0440 || d !== 32'h00FFFFFF) begin
            errors++;
            $display("FAIL write_bus addr=%h data=%h required=0440/00ffffff", a, d);
        end
        checks++;
        if (rdy != 8) begin errors++; $display("FAIL write_ready_return got=%0d required=8", rdy); end
        checks++;
        if (rspany || nrd != 0) begin
            errors++;
            $display("FAIL write_no_rsp rsp_valid_seen=%b read_reg_cycles=%0d required=0/0", rspany, nrd);
        end
    endtask

    task automatic test_read;
        int hs, nrd, vrel, rr;
        logic [31:0] r0, e;
        logic stable;
        nrd = 0; vrel = 0; rr = 0; stable = 1'b1;
        ovr_en = 1'b1;
        ovr = 32'h11111111;
        exp_q.push_back(32'h11111111);
        issue(1'b0, 16'h0304, 32'h0, hs);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (read_reg) nrd++;
            if (rsp_valid) begin
                vrel = i;
                break;
            end
        end
        checks++;
        if (nrd != 1) begin errors++; $display("FAIL read_strobe_len got=%0d required=1", nrd); end
        checks++;
        if (vrel != 7) begin errors++; $display("FAIL read_latency got=%0d required=7", vrel); end
        r0 = rsp_rdata;
        ovr = 32'h22222222;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== r0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL read_hold_stable got=0 required=1"); end
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== e) begin errors++; $display("FAIL read_data got=%h required=%h", rsp_rdata, e); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rsp_ready = 1'b0;
                checks++;
                if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_valid_clear got=%b required=0", rsp_valid); end
            end
            if (cmd_ready && rr == 0) rr = k;
        end
        checks++;
        if (rr != 3) begin errors++; $display("FAIL read_gap got=%0d required=3", rr); end
        ovr_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        int h1, h2, fall, sp;
        logic prev, stb, ovl, seen;
        logic [13:0] wa, ra;
        logic [31:0] e;
        h2 = -1; fall = -1; sp = 999; prev = 1'b0; ovl = 1'b0; seen = 1'b0; wa = '0; ra = '0;
        exp_q.push_back(32'hCAFEF00D);
        issue(1'b1, 16'h1000, 32'hCAFEF00D, h1);
        prev = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h1003;
        cmd_wdata = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            stb = write_reg | read_reg;
            if (write_reg && read_reg) ovl = 1'b1;
            if (stb && !prev && fall >= 0 && cyc - fall < sp) sp = cyc - fall;
            if (!stb && prev) fall = cyc;
            if (write_reg) wa = busaddress;
            if (read_reg) ra = busaddress;
            prev = stb;
            if (cmd_valid && cmd_ready) begin
                h2 = cyc + 1;
                seen = 1'b1;
            end else if (seen) cmd_valid = 1'b0;
            if (rsp_valid) break;
        end
        cmd_valid = 1'b0;
        checks++;
        if (h2 - h1 != 8) begin errors++; $display("FAIL b2b_handshake got=%0d required=8", h2 - h1); end
        checks++;
        if (sp < 3 || sp == 999) begin errors++; $display("FAIL b2b_spacing got=%0d required>=3", sp); end
        checks++;
        if (ovl) begin errors++; $display("FAIL b2b_overlap got=1 required=0"); end
        checks++;
        if (wa !== 14'h0400 || ra !== 14'h0400) begin
            errors++;
            $display("FAIL addr_lsbs_ignored write=%h read=%h required=0400", wa, ra);
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL b2b_rsp_timeout rsp_valid=%b required=1", rsp_valid);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_rdata !== e) begin errors++; $display("FAIL b2b_read_data got=%h required=%h", rsp_rdata, e); end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_short_timing;
        int hs, nrd, vrel, rr;
        logic [31:0] e;
        nrd = 0; vrel = 0; rr = 0;
        exp_q.push_back(32'h5A5A0003);
        b_write = 1'b0;
        b_addr  = 16'h0010;
        b_valid = 1'b1;
        for (int i = 0; i < 40 && !b_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        hs = cyc;
        b_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b_rreg) nrd++;
            if (b_rsp_valid) begin
                vrel = i;
                break;
            end
        end
        checks++;
        if (nrd != 3) begin errors++; $display("FAIL short_strobe_len got=%0d required=3", nrd); end
        checks++;
        if (vrel != 5) begin errors++; $display("FAIL short_latency got=%0d required=5", vrel); end
        e = exp_q.pop_front();
        checks++;
        if (b_rdata !== e) begin errors++; $display("FAIL short_data got=%h required=%h", b_rdata, e); end
        b_rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) b_rsp_ready = 1'b0;
            if (b_ready && rr == 0) rr = k;
        end
        checks++;
        if (rr != 2) begin errors++; $display("FAIL short_gap got=%0d required=2 (hs=%0d)", rr, hs); end
    endtask

    task automatic test_reset_mid;
        int hs, vc;
        logic any;
        logic [31:0] d, e;
        any = 1'b0;
        issue(1'b0, 16'h1100, 32'h0, hs);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_in = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy, chip_sel, write_reg, read_reg} !== 6'b0 || busaddress !== 14'h0 || busdata_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs ctrl=%b addr=%h required=0", {cmd_ready, rsp_valid, busy, chip_sel, write_reg, read_reg}, busaddress);
        end
        @(negedge clk);
        reset_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) any = 1'b1;
        end
        checks++;
        if (any) begin errors++; $display("FAIL reset_mid_no_rsp got=1 required=0"); end
        exp_q.push_back(shadow[8'h40]);
        issue(1'b0, 16'h1100, 32'h0, hs);
        cmd_valid = 1'b0;
        get_rsp(d, vc);
        if (vc >= 0) begin
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL reset_recover_data got=%h required=%h", d, e); end
            checks++;
            if (vc - hs + 1 != 7) begin errors++; $display("FAIL reset_recover_latency got=%0d required=7", vc - hs + 1); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_short_timing();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
